// File: rtl/hub75_pixel_fetch_if.sv
// Bus bundle between the HUB75 framebuffer and its pixel writer / scan driver.
// Slave is the framebuffer; master is the writer plus scan driver.
interface hub75_pixel_fetch_if #(
    parameter int COLS      = 64,
    parameter int ROW_PAIRS = 32,
    parameter int CDEPTH    = 4
);
    localparam int CB = $clog2(COLS);
    localparam int YB = $clog2(2 * ROW_PAIRS);
    localparam int RB = $clog2(ROW_PAIRS);
    localparam int PB = $clog2(CDEPTH);

    logic                  wr_valid;
    logic                  wr_ready;
    logic [CB-1:0]         wr_x;
    logic [YB-1:0]         wr_y;
    logic [3*CDEPTH-1:0]   wr_rgb;
    logic                  swap_req;
    logic                  swap_done;
    logic                  req_valid;
    logic [RB-1:0]         req_row;
    logic [CB-1:0]         req_col;
    logic [PB-1:0]         req_plane;
    logic                  px_valid;
    logic [5:0]            px_rgb;

    modport master (
        output wr_valid, wr_x, wr_y, wr_rgb, swap_req,
        output req_valid, req_row, req_col, req_plane,
        input  wr_ready, swap_done, px_valid, px_rgb
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_rgb, swap_req,
        input  req_valid, req_row, req_col, req_plane,
        output wr_ready, swap_done, px_valid, px_rgb
    );
endinterface

// File: rtl/hub75_pixel_fetch.sv
// Double-buffered RGB444 framebuffer for a HUB75 scan driver: writer fills the back buffer,
// scan reads return one bit plane of the front buffer, swap happens only at frame end.
module hub75_pixel_fetch #(
    parameter int COLS      = 64,
    parameter int ROW_PAIRS = 32,
    parameter int CDEPTH    = 4
) (
    input  logic                  CLK100MHZ,
    input  logic                  CPU_RESETN,
    hub75_pixel_fetch_if.slave    bus
);
    localparam int CB    = $clog2(COLS);
    localparam int RB    = $clog2(ROW_PAIRS);
    localparam int PB    = $clog2(CDEPTH);
    localparam int W     = 3 * CDEPTH;
    localparam int AW    = 1 + RB + CB;
    localparam int DEPTH = 2 * ROW_PAIRS * COLS;

    localparam logic [RB-1:0] LAST_ROW   = RB'(ROW_PAIRS - 1);
    localparam logic [CB-1:0] LAST_COL   = CB'(COLS - 1);
    localparam logic [PB-1:0] LAST_PLANE = PB'(CDEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_clr_addr;
    logic            r_wr_ready;
    logic            r_front;
    logic            r_swap_pending;
    logic            r_swap_done;
    logic            r_rd_valid;
    logic [AW-1:0]   r_rd_addr;
    logic [PB-1:0]   r_rd_plane;
    logic            r_px_valid;
    logic [5:0]      r_px_rgb;

    // One RAM per panel half so a single read address yields both scan lines.
    logic [W-1:0]    r_mem_u [DEPTH];
    logic [W-1:0]    r_mem_l [DEPTH];

    logic            w_clearing;
    logic            w_wr_fire;
    logic            w_lower;
    logic [AW-1:0]   w_waddr;
    logic [W-1:0]    w_wdata;
    logic            w_we_u;
    logic            w_we_l;
    logic            w_frame_end;
    logic [W-1:0]    w_rd_u;
    logic [W-1:0]    w_rd_l;
    logic [5:0]      w_px;

    assign w_clearing  = (r_state == ST_CLEAR);
    assign w_wr_fire   = bus.wr_valid & r_wr_ready;
    assign w_lower     = bus.wr_y[RB];
    assign w_waddr     = w_clearing ? r_clr_addr : {~r_front, bus.wr_y[RB-1:0], bus.wr_x};
    assign w_wdata     = w_clearing ? '0 : bus.wr_rgb;
    assign w_we_u      = w_clearing | (w_wr_fire & ~w_lower);
    assign w_we_l      = w_clearing | (w_wr_fire &  w_lower);

    assign w_frame_end = (r_state == ST_RUN) && r_swap_pending && bus.req_valid &&
                         (bus.req_row == LAST_ROW) && (bus.req_col == LAST_COL) &&
                         (bus.req_plane == LAST_PLANE);

    assign w_rd_u = r_mem_u[r_rd_addr];
    assign w_rd_l = r_mem_l[r_rd_addr];

    always_comb begin
        logic [CDEPTH-1:0] w_ru, w_gu, w_bu, w_rl, w_gl, w_bl;
        w_ru = w_rd_u[W-1 -: CDEPTH];
        w_gu = w_rd_u[2*CDEPTH-1 -: CDEPTH];
        w_bu = w_rd_u[CDEPTH-1:0];
        w_rl = w_rd_l[W-1 -: CDEPTH];
        w_gl = w_rd_l[2*CDEPTH-1 -: CDEPTH];
        w_bl = w_rd_l[CDEPTH-1:0];
        w_px = {w_ru[r_rd_plane], w_gu[r_rd_plane], w_bu[r_rd_plane],
                w_rl[r_rd_plane], w_gl[r_rd_plane], w_bl[r_rd_plane]};
    end

    always_ff @(posedge CLK100MHZ) begin
        if (w_we_u) r_mem_u[w_waddr] <= w_wdata;
        if (w_we_l) r_mem_l[w_waddr] <= w_wdata;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state        <= ST_CLEAR;
            r_clr_addr     <= '0;
            r_wr_ready     <= 1'b0;
            r_front        <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_done    <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_rd_addr      <= '0;
            r_rd_plane     <= '0;
            r_px_valid     <= 1'b0;
            r_px_rgb       <= '0;
        end else begin
            r_swap_done <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + AW'(1);
                    if (r_clr_addr == '1) begin
                        r_state    <= ST_RUN;
                        r_wr_ready <= 1'b1;
                    end
                end
                ST_RUN:  r_wr_ready <= 1'b1;
                default: r_state    <= ST_CLEAR;
            endcase

            // A request coinciding with frame end with nothing pending is only latched.
            if (w_frame_end) begin
                r_front        <= ~r_front;
                r_swap_pending <= 1'b0;
                r_swap_done    <= 1'b1;
            end else if (bus.swap_req) begin
                r_swap_pending <= 1'b1;
            end

            r_rd_valid <= bus.req_valid;
            if (bus.req_valid) begin
                r_rd_addr  <= {r_front, bus.req_row, bus.req_col};
                r_rd_plane <= bus.req_plane;
            end

            r_px_valid <= r_rd_valid;
            if (r_rd_valid) r_px_rgb <= w_px;
        end
    end

    assign bus.wr_ready  = r_wr_ready;
    assign bus.swap_done = r_swap_done;
    assign bus.px_valid  = r_px_valid;
    assign bus.px_rgb    = r_px_rgb;
endmodule

// File: tb/tb_hub75_pixel_fetch.sv
// Scoreboard bench for hub75_pixel_fetch: reads push expected words, a negedge monitor
// pops and checks value and arrival cycle whenever px_valid is seen.
`timescale 1ns/1ps
module tb_hub75_pixel_fetch;
    localparam int COLS      = 64;
    localparam int ROW_PAIRS = 32;
    localparam int CDEPTH    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hub75_pixel_fetch_if #(.COLS(COLS), .ROW_PAIRS(ROW_PAIRS), .CDEPTH(CDEPTH)) bus();

    hub75_pixel_fetch #(.COLS(COLS), .ROW_PAIRS(ROW_PAIRS), .CDEPTH(CDEPTH)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .bus       (bus.slave)
    );

    typedef struct packed {
        logic [5:0]  rgb;
        int unsigned due;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_strobes();
        bus.wr_valid  = 1'b0;
        bus.swap_req  = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr_strobes();
    endtask

    task automatic set_rd(input logic [4:0] row, input logic [5:0] col, input logic [1:0] plane,
                          input logic [5:0] exp);
        bus.req_valid = 1'b1;
        bus.req_row   = row;
        bus.req_col   = col;
        bus.req_plane = plane;
        q.push_back('{rgb: exp, due: cyc + 2});
    endtask

    task automatic set_wr(input logic [5:0] x, input logic [5:0] y, input logic [11:0] rgb);
        bus.wr_valid = 1'b1;
        bus.wr_x     = x;
        bus.wr_y     = y;
        bus.wr_rgb   = rgb;
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.wr_ready && n < 5000);
        chk(name, n, 4096);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_ready"},  32'(bus.wr_ready),  0);
        chk({tag, "_px_valid"},  32'(bus.px_valid),  0);
        chk({tag, "_px_rgb"},    32'(bus.px_rgb),    0);
        chk({tag, "_swap_done"}, 32'(bus.swap_done), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.px_valid) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL px_unexpected: got %b at cyc %0d expected no output", bus.px_rgb, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (bus.px_rgb !== e.rgb || cyc != e.due) begin
                        n_err++;
                        $display("FAIL px_rgb: got %b at cyc %0d expected %b at cyc %0d",
                                 bus.px_rgb, cyc, e.rgb, e.due);
                    end
                end
            end else if (q.size() > 0 && q[0].due < cyc) begin
                exp_t e;
                e = q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL px_missing: got no px_valid at cyc %0d expected %b", cyc, e.rgb);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        clr_strobes();
        bus.wr_x = '0; bus.wr_y = '0; bus.wr_rgb = '0;
        bus.req_row = '0; bus.req_col = '0; bus.req_plane = '0;

        // Reset state and clear length
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk); #2 rst_n = 1'b1;
        wait_clear("clear_len");
        set_rd(0, 0, 0, 6'b000000);   step();
        set_rd(17, 33, 1, 6'b000000); step();
        set_rd(31, 63, 3, 6'b000000); step();

        // Write into back buffer, swap over a full frame sweep
        set_wr(5, 3, 12'hF80); step();
        bus.swap_req = 1'b1; step();
        for (int r = 0; r < ROW_PAIRS; r++)
            for (int c = 0; c < COLS; c++)
                for (int p = 0; p < CDEPTH; p++) begin
                    set_rd(5'(r), 6'(c), 2'(p), 6'b000000);
                    step();
                end
        chk("swap_done_frame", 32'(bus.swap_done), 1);
        step();
        chk("swap_done_pulse", 32'(bus.swap_done), 0);
        set_rd(3, 5, 3, 6'b110000); step();
        set_rd(3, 5, 0, 6'b100000); step();

        // 200-cycle back-to-back burst
        for (int i = 0; i < 200; i++) begin
            set_rd(3, 6'(i % COLS), 3, ((i % COLS) == 5) ? 6'b110000 : 6'b000000);
            step();
        end

        // Lower-half write, swap back
        set_wr(0, 40, 12'h00F); step();
        bus.swap_req = 1'b1; step();
        set_rd(31, 63, 3, 6'b000000); step();
        chk("swap_done_t3", 32'(bus.swap_done), 1);
        set_rd(8, 0, 2, 6'b000001); step();
        set_rd(3, 5, 3, 6'b000000); step();

        // Pending swap: old front until frame end, second request absorbed
        bus.swap_req = 1'b1;
        set_rd(10, 0, 0, 6'b000000); step();
        chk("no_swap_row10", 32'(bus.swap_done), 0);
        set_rd(3, 5, 3, 6'b000000); step();
        bus.swap_req = 1'b1;
        set_rd(31, 63, 2, 6'b000000); step();
        chk("no_swap_plane2", 32'(bus.swap_done), 0);
        set_rd(31, 62, 3, 6'b000000); step();
        chk("no_swap_col62", 32'(bus.swap_done), 0);
        set_rd(31, 63, 3, 6'b000000); step();
        chk("swap_done_t4", 32'(bus.swap_done), 1);
        pulses = 0;
        repeat (8) begin
            step();
            if (bus.swap_done) pulses++;
        end
        chk("no_second_swap", pulses, 0);
        set_rd(3, 5, 3, 6'b110000); step();

        // swap_req coincident with frame end is only latched
        bus.swap_req = 1'b1;
        set_rd(31, 63, 3, 6'b000000); step();
        chk("coincident_no_swap", 32'(bus.swap_done), 0);
        set_rd(3, 5, 3, 6'b110000); step();
        // Write on the swap edge goes to the old back buffer
        set_rd(31, 63, 3, 6'b000000);
        set_wr(7, 2, 12'h0F0); step();
        chk("swap_done_t5", 32'(bus.swap_done), 1);
        set_rd(2, 7, 1, 6'b010000); step();
        set_rd(8, 0, 2, 6'b000001); step();

        // Mid-frame reset with reads and writes active
        for (int i = 0; i < 4; i++) begin
            set_rd(2, 7, 1, 6'b010000);
            set_wr(6'(i), 20, 12'hABC);
            step();
        end
        bus.req_valid = 1'b1;
        set_wr(4, 20, 12'hABC);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        q.delete();
        clr_strobes();
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        wait_clear("reclear_len");
        set_rd(2, 7, 1, 6'b000000); step();
        set_rd(8, 0, 2, 6'b000000); step();
        set_rd(3, 5, 3, 6'b000000); step();

        repeat (6) step();
        chk("sb_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
